// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t   : converter FSM states (ST_IDLE, ST_SHIFT, ST_DONE)
//   BCD_BLANK : digit code shown for a blanked leading zero
//   clog2     : ceiling log2, used to size the bit counter
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digito_add3.sv
// Double-dabble correction cell for one BCD digit: a digit of 5 or more
// gets +3 so that the following left shift carries correctly into the
// next decade.
//   digito    in  4  current digit (0..9 in normal operation)
//   ajustado  out 4  corrected digit, ready to be shifted
module bcd_digito_add3 (
    input  logic [3:0] digito,
    output logic [3:0] ajustado
);

    assign ajustado = (digito >= 4'd5) ? digito + 4'd3 : digito;

endmodule

// File: rtl/bcd_conversor_sequencial.sv
// Multi-cycle binary-to-BCD converter (shift-add-3), one input bit per clock.
// A start in IDLE captures the magnitude and sign of numero; WIDTH shift
// cycles follow, then one DONE cycle publishes the result with a done pulse.
//   clk        in   1         rising-edge clock
//   reset      in   1         synchronous, active-high reset
//   start      in   1         conversion request, honoured only in IDLE
//   numero     in   WIDTH     value to convert, captured on the accepted start
//   com_sinal  in   1         1 = numero is two's complement
//   busy       out  1         high in SHIFT and DONE
//   done       out  1         one-cycle pulse when outputs are updated
//   sinal      out  1         result is negative
//   bcd        out  4*DIGITS  result digits, unit digit in [3:0]
//   overflow   out  1         magnitude >= 10**DIGITS (bcd keeps the low digits)
// Build option: define BCD_LEADING_ZERO_BLANK_EN to show leading zero digits
// as BCD_BLANK (the unit digit is never blanked; blanking is off on overflow).
module bcd_conversor_sequencial
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    numero,
    input  logic                com_sinal,
    output logic                busy,
    output logic                done,
    output logic                sinal,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow
);

    localparam int               CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [WIDTH-1:0]      mag_q;
    logic [4*DIGITS-1:0]   acc_q;
    logic                  acc_ovf_q;
    logic                  sign_q;

    logic                  done_q;
    logic                  sinal_q;
    logic                  overflow_q;
    logic [4*DIGITS-1:0]   bcd_q;

    logic                  negativo;
    logic [WIDTH-1:0]      mag_in;
    logic [4*DIGITS-1:0]   acc_adj;
    logic [4*DIGITS-1:0]   acc_next;
    logic                  carry_top;
    logic [4*DIGITS-1:0]   bcd_final;

    // Magnitude of the input; -2**(WIDTH-1) negates to itself, which is the
    // correct unsigned magnitude.
    assign negativo = com_sinal & numero[WIDTH-1];
    assign mag_in   = negativo ? -numero : numero;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_digito_add3 u_add3 (
                .digito   (acc_q[4*g +: 4]),
                .ajustado (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // The bit leaving the top digit is worth 10**DIGITS: it marks overflow.
    assign carry_top = acc_adj[4*DIGITS-1];
    assign acc_next  = {acc_adj[4*DIGITS-2:0], mag_q[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST_BIT) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bcd_final = acc_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        begin : blank
            logic leading;
            leading = !acc_ovf_q;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (leading && (acc_q[4*i +: 4] == 4'd0)) bcd_final[4*i +: 4] = BCD_BLANK;
                else                                      leading = 1'b0;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the working registers are reset along with the outputs so an
    // aborted conversion leaves nothing behind that could reach the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            mag_q      <= '0;
            acc_q      <= '0;
            acc_ovf_q  <= 1'b0;
            sign_q     <= 1'b0;
            done_q     <= 1'b0;
            sinal_q    <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mag_q     <= mag_in;
                        sign_q    <= negativo;
                        acc_q     <= '0;
                        acc_ovf_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                ST_SHIFT: begin
                    acc_q     <= acc_next;
                    mag_q     <= {mag_q[WIDTH-2:0], 1'b0};
                    acc_ovf_q <= acc_ovf_q | carry_top;
                    cnt_q     <= cnt_q + 1'b1;
                end
                ST_DONE: begin
                    bcd_q      <= bcd_final;
                    sinal_q    <= sign_q;
                    overflow_q <= acc_ovf_q;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign sinal    = sinal_q;
    assign overflow = overflow_q;
    assign bcd      = bcd_q;

endmodule

// File: tb/tb_bcd_conversor_sequencial.sv
// Bench for bcd_conversor_sequencial: a 32-bit/10-digit instance and a
// 16-bit/4-digit instance run side by side against an arithmetic model.
module tb_bcd_conversor_sequencial;

    typedef struct packed {
        logic [39:0] bcd;
        logic        sinal;
        logic        ovf;
    } res_t;

    localparam int W_OF [2] = '{32, 16};
    localparam int D_OF [2] = '{10, 4};

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [39:0] L1234 = 40'hFFFFFF1234;
    localparam logic [39:0] L4321 = 40'hFFFFFF4321;
    localparam logic [39:0] L0    = 40'hFFFFFFFFF0;
    localparam logic [39:0] L507  = 40'hFFFFFFF507;
`else
    localparam logic [39:0] L1234 = 40'h0000001234;
    localparam logic [39:0] L4321 = 40'h0000004321;
    localparam logic [39:0] L0    = 40'h0000000000;
    localparam logic [39:0] L507  = 40'h0000000507;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v   [2];
    logic [31:0] numero_v  [2];
    logic        com_v     [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        sinal_v   [2];
    logic        ovf_v     [2];
    logic [39:0] bcd0;
    logic [15:0] bcd4;

    int vectors = 0;
    int errors  = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    bcd_conversor_sequencial #(.WIDTH(32), .DIGITS(10)) dut32 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_v[0]),
        .numero    (numero_v[0]),
        .com_sinal (com_v[0]),
        .busy      (busy_v[0]),
        .done      (done_v[0]),
        .sinal     (sinal_v[0]),
        .bcd       (bcd0),
        .overflow  (ovf_v[0])
    );

    bcd_conversor_sequencial #(.WIDTH(16), .DIGITS(4)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_v[1]),
        .numero    (numero_v[1][15:0]),
        .com_sinal (com_v[1]),
        .busy      (busy_v[1]),
        .done      (done_v[1]),
        .sinal     (sinal_v[1]),
        .bcd       (bcd4),
        .overflow  (ovf_v[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal arithmetic reference: magnitude, modulo 10**d, digit split.
    function automatic res_t ref_conv(input logic [31:0] n, input logic s, input int w, input int d);
        longint unsigned mag, lim, v, digit;
        int   sig;
        res_t r;
        mag     = {32'd0, n} & ((64'd1 << w) - 64'd1);
        r.sinal = s && (((mag >> (w - 1)) & 64'd1) == 64'd1);
        if (r.sinal) mag = (64'd1 << w) - mag;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        r.ovf = (mag >= lim);
        v     = mag % lim;
        r.bcd = '0;
        sig   = 1;
        for (int i = 0; i < d; i++) begin
            digit = v % 10;
            r.bcd[4*i +: 4] = 4'(digit);
            if (digit != 0) sig = i + 1;
            v = v / 10;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (!r.ovf)
            for (int i = sig; i < d; i++) r.bcd[4*i +: 4] = 4'hF;
`endif
        return r;
    endfunction

    // Timing model: an accepted request completes WIDTH+1 edges later.
    int          m_cnt     [2];
    res_t        m_res     [2];
    logic        exp_busy  [2];
    logic        exp_done  [2];
    logic        exp_sinal [2];
    logic        exp_ovf   [2];
    logic [39:0] exp_bcd   [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i]     <= 0;
                exp_busy[i]  <= 1'b0;
                exp_done[i]  <= 1'b0;
                exp_sinal[i] <= 1'b0;
                exp_ovf[i]   <= 1'b0;
                exp_bcd[i]   <= '0;
            end else begin
                exp_done[i] <= 1'b0;
                if (m_cnt[i] == 0) begin
                    if (start_v[i]) begin
                        m_cnt[i]    <= W_OF[i] + 1;
                        m_res[i]    <= ref_conv(numero_v[i], com_v[i], W_OF[i], D_OF[i]);
                        exp_busy[i] <= 1'b1;
                    end
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        exp_busy[i]  <= 1'b0;
                        exp_done[i]  <= 1'b1;
                        exp_bcd[i]   <= m_res[i].bcd;
                        exp_sinal[i] <= m_res[i].sinal;
                        exp_ovf[i]   <= m_res[i].ovf;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("busy%0d", i),  {63'd0, busy_v[i]},  {63'd0, exp_busy[i]});
                check($sformatf("done%0d", i),  {63'd0, done_v[i]},  {63'd0, exp_done[i]});
                check($sformatf("sinal%0d", i), {63'd0, sinal_v[i]}, {63'd0, exp_sinal[i]});
                check($sformatf("ovf%0d", i),   {63'd0, ovf_v[i]},   {63'd0, exp_ovf[i]});
                check($sformatf("bcd%0d", i),
                      (i == 0) ? {24'd0, bcd0} : {48'd0, bcd4}, {24'd0, exp_bcd[i]});
            end
        end
    end

    task automatic convert(input int idx, input logic [31:0] n, input logic s, output int lat);
        @(negedge clk);
        start_v[idx]  = 1'b1;
        numero_v[idx] = n;
        com_v[idx]    = s;
        @(negedge clk);
        start_v[idx] = 1'b0;
        lat = 1;
        while (!done_v[idx] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", {63'd0, done_v[idx]}, 64'd1);
    endtask

    initial begin
        int lat;
        int dones;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; numero_v[i] = '0; com_v[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        check("rst_busy",  {63'd0, busy_v[0]}, 64'd0);
        check("rst_done",  {63'd0, done_v[0]}, 64'd0);
        check("rst_bcd",   {24'd0, bcd0},      64'd0);
        check("rst_sinal", {63'd0, sinal_v[0]}, 64'd0);
        reset = 1'b0;

        convert(0, 32'd1234, 1'b0, lat);
        check("lat_1234",   lat, 64'd34);
        check("bcd_1234",   {24'd0, bcd0}, {24'd0, L1234});
        check("sinal_1234", {63'd0, sinal_v[0]}, 64'd0);
        check("ovf_1234",   {63'd0, ovf_v[0]}, 64'd0);

        convert(0, 32'hFFFFFB2E, 1'b1, lat);
        check("bcd_m1234",   {24'd0, bcd0}, {24'd0, L1234});
        check("sinal_m1234", {63'd0, sinal_v[0]}, 64'd1);

        convert(0, 32'hFFFFFB2E, 1'b0, lat);
        check("bcd_u_fffffb2e",   {24'd0, bcd0}, 64'h4294966062);
        check("sinal_u_fffffb2e", {63'd0, sinal_v[0]}, 64'd0);

        convert(0, 32'h80000000, 1'b1, lat);
        check("bcd_minneg",   {24'd0, bcd0}, 64'h2147483648);
        check("sinal_minneg", {63'd0, sinal_v[0]}, 64'd1);
        check("ovf_minneg",   {63'd0, ovf_v[0]}, 64'd0);

        convert(0, 32'd0, 1'b1, lat);
        check("bcd_zero",   {24'd0, bcd0}, {24'd0, L0});
        check("sinal_zero", {63'd0, sinal_v[0]}, 64'd0);
        convert(0, 32'd507, 1'b0, lat);
        check("bcd_507", {24'd0, bcd0}, {24'd0, L507});

        convert(1, 32'd12345, 1'b0, lat);
        check("lat_d4",      lat, 64'd18);
        check("bcd_d4_12345", {48'd0, bcd4}, 64'h2345);
        check("ovf_d4_12345", {63'd0, ovf_v[1]}, 64'd1);
        convert(1, 32'd9999, 1'b0, lat);
        check("bcd_d4_9999", {48'd0, bcd4}, 64'h9999);
        check("ovf_d4_9999", {63'd0, ovf_v[1]}, 64'd0);

        // A second start during a conversion must be dropped.
        @(negedge clk);
        start_v[0] = 1'b1; numero_v[0] = 32'd1234; com_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        start_v[0] = 1'b1; numero_v[0] = 32'd999;
        @(negedge clk);
        start_v[0] = 1'b0;
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        check("ignored_start_dones", dones, 64'd1);
        check("ignored_start_bcd", {24'd0, bcd0}, {24'd0, L1234});

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        start_v[0] = 1'b1; numero_v[0] = 32'd77;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        check("abort_dones", dones, 64'd0);
        check("abort_bcd",   {24'd0, bcd0}, 64'd0);
        check("abort_busy",  {63'd0, busy_v[0]}, 64'd0);
        convert(0, 32'd4321, 1'b0, lat);
        check("after_abort_bcd", {24'd0, bcd0}, {24'd0, L4321});

        // Random traffic on both instances: held starts, mid-run input
        // changes and occasional resets.
        repeat (4000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < 2; i++) begin
                start_v[i]  = ($urandom_range(0, 3) != 0);
                numero_v[i] = $urandom;
                com_v[i]    = $urandom_range(0, 1) == 1;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) start_v[i] = 1'b0;
        repeat (60) @(negedge clk);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
